control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that replaces the hand-sequenced control strobes currently driven into `datapath` by the phase-1 benches. Steps each instruction through fetch (T0–T2) and execute (T3–T6) states, decodes register fields from the IR into one-hot `Rin`/`Rout` selects, and waits on a memory-ready handshake during fetch. It sits beside `datapath`, and every strobe output connects 1:1 to the like-named `datapath` input.

## Interface
- Parameters: none.
- `clock` in 1: sole clock; all state changes occur on the rising edge.
- `clear` in 1: asynchronous, active-low reset (0 = reset).
- `run` in 1: enables instruction sequencing; sampled in IDLE and at the end of each instruction.
- `mem_ready` in 1: memory data is valid on `Mdatain` this cycle.
- `ir` in 32: IR contents. `ir[31:27]` is the opcode, `ir[26:23]` is Ra, `ir[22:19]` is Rb, `ir[18:15]` is Rc.
- `step` in 1: single-step advance pulse; present only with `CTRL_SINGLE_STEP_EN`.
- `Rin` out 16: one-hot register write enables (bit n drives RnIn).
- `Rout` out 16: one-hot register bus drives.
- `PCout`, `PCin`, `incPC`, `MARin`, `MDRin`, `MDRout`, `read`, `IRin`, `Yin`, `Zin`, `ZLowOut`, `ZHighOut`, `HIin`, `LOin` out 1 each: datapath strobes.
- `opcode` out 5: ALU operation.
- `busy` out 1: high in any state other than IDLE and HALTED.
- `instr_done` out 1: one-cycle pulse in an instruction's final state.
- `illegal` out 1: one-cycle pulse in T3 when the opcode is unsupported.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED. The state is registered; all outputs are a Moore decode of state + `ir`.
- Reset value of every output is 0, except `opcode` = 5'b11010 (nop). The state resets to IDLE.
- IDLE: all outputs 0. When `run`=1, go to T0.
- T0: `PCout`, `MARin`, `incPC`, `Zin`.
- T1: `ZLowOut`, `PCin`, `read`, `MDRin`. Hold in T1 until `mem_ready`=1. `PCin` is asserted only in the T1 cycle where `mem_ready`=1, so PC updates exactly once.
- T2: `MDRout`, `IRin`.
- Three-operand ALU ops (opcode 00000–01011, e.g. add, sub, and, or, shr, shra, shl, ror=00111, rol):
  - T3: `Rout`[Rb], `Yin`.
  - T4: `Rout`[Rc], `opcode`=ir[31:27], `Zin`.
  - T5: `ZLowOut`, `Rin`[Ra], `instr_done`.
- mul (01111) / div (10000):
  - T3: `Rout`[Ra], `Yin`.
  - T4: `Rout`[Rb], `opcode`, `Zin`.
  - T5: `ZLowOut`, `LOin`.
  - T6: `ZHighOut`, `HIin`, `instr_done`.
- neg (10010) / not (10011):
  - T3: no strobes.
  - T4: `Rout`[Rb], `opcode`, `Zin`.
  - T5: `ZLowOut`, `Rin`[Ra], `instr_done`.
- nop (11010): T3 asserts `instr_done`.
- halt (11011): T3 asserts `instr_done`, then the sequencer goes to HALTED. It leaves HALTED only via `clear`.
- Any other opcode: T3 asserts `illegal` and `instr_done`; no register is written.
- After an instruction's final state: go to T0 if `run`=1, otherwise IDLE.
- Outside the listed states, `opcode` holds 11010. `Rin` and `Rout` are never multi-hot.

## Timing
- ALU, neg, and not instructions take 6 cycles (T0–T5) with `mem_ready` high on the first T1 cycle. mul and div take 7 cycles. nop, halt, and illegal opcodes take 4 cycles.
- Each cycle of `mem_ready`=0 in T1 adds one cycle of latency.
- `run` dropping mid-instruction has no effect until the instruction completes.
- `clear` low at any point, including in T1 or T4, forces IDLE and all-zero strobes asynchronously. There is no partial register write: any `Rin` pulse is aborted.
- In the first cycle after `clear` rises, the sequencer samples `run` from IDLE.

## Configuration
- `CTRL_SINGLE_STEP_EN` defined: the `step` port exists. Each state advance, including IDLE→T0, additionally requires `step`=1 in that cycle. Outputs hold while waiting. In T1, the advance requires both `step` and `mem_ready`.
- Not defined: there is no `step` port, and states advance every cycle as described above.

## Test plan
- Reset: hold `clear`=0 → all strobes 0, `Rin`=`Rout`=0, `opcode`=11010, `busy`=0.
- ror R4,R3,R7: `ir`=0x3A1B8000, `run`=1, `mem_ready`=1 → T3 `Rout`=0x0008 with `Yin`; T4 `Rout`=0x0080, `opcode`=00111, `Zin`; T5 `ZLowOut`, `Rin`=0x0010, `instr_done`. Total 6 cycles.
- Fetch stall: `mem_ready` low for 3 cycles in T1 → `read`/`MDRin` held 4 cycles; `PCin` high exactly one cycle; the instruction completes in 9 cycles.
- mul R2,R5: opcode 01111, Ra=2, Rb=5 → T3 `Rout`=0x0004; T4 `Rout`=0x0020; T5 `LOin`; T6 `HIin` with `instr_done`.
- halt and illegal: opcode 11011 → HALTED, `busy`=0, ignores `run` until `clear`. Opcode 11111 → `illegal` pulse in T3, `Rin`=0 throughout, next state T0.
- Reset mid-T4 of an add: `clear` low → outputs 0 immediately. After release with `run`=1, the next state is T0.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hardwired fetch/execute control unit driving datapath strobes.
//            Optional macro CTRL_SINGLE_STEP_EN adds a step-gated advance.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        incPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  opcode,
    output logic        busy,
    output logic        instr_done,
    output logic        illegal
);

    localparam logic [4:0] C_OP_NOP  = 5'b11010;
    localparam logic [4:0] C_OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_HALTED = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_adv;
    logic [4:0]  w_op;
    logic [15:0] w_ra_oh;
    logic [15:0] w_rb_oh;
    logic [15:0] w_rc_oh;
    logic        w_is_alu;
    logic        w_is_muldiv;
    logic        w_is_negnot;
    logic        w_is_nop;
    logic        w_is_halt;
    logic        w_unused_ir;

`ifdef CTRL_SINGLE_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif

    assign w_op        = ir[31:27];
    assign w_ra_oh     = 16'd1 << ir[26:23];
    assign w_rb_oh     = 16'd1 << ir[22:19];
    assign w_rc_oh     = 16'd1 << ir[18:15];
    assign w_is_alu    = (w_op <= 5'd11);
    assign w_is_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_is_negnot = (w_op == 5'd18) || (w_op == 5'd19);
    assign w_is_nop    = (w_op == C_OP_NOP);
    assign w_is_halt   = (w_op == C_OP_HALT);
    assign w_unused_ir = ^ir[14:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        Rin        = 16'd0;
        Rout       = 16'd0;
        PCout      = 1'b0;
        PCin       = 1'b0;
        incPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        read       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        ZLowOut    = 1'b0;
        ZHighOut   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        opcode     = C_OP_NOP;
        busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run && w_adv) w_next = S_T0;
            end
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                incPC = 1'b1;
                Zin   = 1'b1;
                if (w_adv) w_next = S_T1;
            end
            S_T1: begin
                ZLowOut = 1'b1;
                read    = 1'b1;
                MDRin   = 1'b1;
                // PC is loaded only on the cycle that actually leaves T1
                if (mem_ready && w_adv) begin
                    PCin   = 1'b1;
                    w_next = S_T2;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                if (w_adv) w_next = S_T3;
            end
            S_T3: begin
                if (w_is_alu) begin
                    Rout = w_rb_oh;
                    Yin  = 1'b1;
                    if (w_adv) w_next = S_T4;
                end else if (w_is_muldiv) begin
                    Rout = w_ra_oh;
                    Yin  = 1'b1;
                    if (w_adv) w_next = S_T4;
                end else if (w_is_negnot) begin
                    if (w_adv) w_next = S_T4;
                end else if (w_is_halt) begin
                    instr_done = 1'b1;
                    if (w_adv) w_next = S_HALTED;
                end else begin
                    instr_done = 1'b1;
                    illegal    = !w_is_nop;
                    if (w_adv) w_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                Rout   = w_is_alu ? w_rc_oh : w_rb_oh;
                opcode = w_op;
                Zin    = 1'b1;
                if (w_adv) w_next = S_T5;
            end
            S_T5: begin
                ZLowOut = 1'b1;
                if (w_is_muldiv) begin
                    LOin = 1'b1;
                    if (w_adv) w_next = S_T6;
                end else begin
                    Rin        = w_ra_oh;
                    instr_done = 1'b1;
                    if (w_adv) w_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                ZHighOut   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
                if (w_adv) w_next = run ? S_T0 : S_IDLE;
            end
            S_HALTED: begin
                w_next = S_HALTED;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Scoreboard bench for control_sequencer (per-cycle strobe vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcout, pcin, incpc, marin, mdrin, mdrout, rd, irin;
        logic yin, zin, zlow, zhigh, hiin, loin;
        logic [4:0] opc;
        logic busy, done, ill;
    } outv_t;

    typedef struct packed {
        logic [31:0] ir;
        logic        mr;
        logic        rn;
    } stim_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0]  opcode;
    logic        busy, instr_done, illegal;
    outv_t       act;

    int n_total = 0;
    int n_pass  = 0;

    outv_t exp_q[$];
    stim_t stim_q[$];

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
`ifdef CTRL_SINGLE_STEP_EN
        .step(1'b1),
`endif
        .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .incPC(incPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .read(read), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .HIin(HIin), .LOin(LOin), .opcode(opcode), .busy(busy),
        .instr_done(instr_done), .illegal(illegal)
    );

    assign act = {Rin, Rout, PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin,
                  Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, opcode, busy,
                  instr_done, illegal};

    function automatic outv_t base(input logic b);
        outv_t e;
        e      = '0;
        e.opc  = 5'b11010;
        e.busy = b;
        return e;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input int ra,
                                          input int rb, input int rc);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    task automatic push_cyc(input outv_t e, input logic [31:0] irv,
                            input logic mr, input logic rn);
        stim_t s;
        s.ir = irv;
        s.mr = mr;
        s.rn = rn;
        exp_q.push_back(e);
        stim_q.push_back(s);
    endtask

    task automatic push_idle(input logic rn, input logic [31:0] irv);
        push_cyc(base(1'b0), irv, 1'($urandom_range(0, 1)), rn);
    endtask

    // Expected strobe sequence for one instruction, built from the opcode table.
    task automatic push_instr(input logic [31:0] irv, input int stalls, input logic run_end);
        outv_t       e;
        logic        rmid;
        logic [4:0]  op;
        logic [15:0] ra, rb, rc;
        rmid = ~run_end;
        op   = irv[31:27];
        ra   = 16'd1 << irv[26:23];
        rb   = 16'd1 << irv[22:19];
        rc   = 16'd1 << irv[18:15];

        e = base(1); e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
        push_cyc(e, irv, 1'($urandom_range(0, 1)), rmid);
        for (int i = 0; i < stalls; i++) begin
            e = base(1); e.zlow = 1; e.rd = 1; e.mdrin = 1;
            push_cyc(e, irv, 1'b0, rmid);
        end
        e = base(1); e.zlow = 1; e.rd = 1; e.mdrin = 1; e.pcin = 1;
        push_cyc(e, irv, 1'b1, rmid);
        e = base(1); e.mdrout = 1; e.irin = 1;
        push_cyc(e, irv, 1'($urandom_range(0, 1)), rmid);

        if (op <= 5'd11 || op == 5'd15 || op == 5'd16 || op == 5'd18 || op == 5'd19) begin
            e = base(1);
            if (op <= 5'd11) begin e.rout = rb; e.yin = 1; end
            else if (op == 5'd15 || op == 5'd16) begin e.rout = ra; e.yin = 1; end
            push_cyc(e, irv, 1'($urandom_range(0, 1)), rmid);
            e = base(1); e.opc = op; e.zin = 1;
            e.rout = (op <= 5'd11) ? rc : rb;
            push_cyc(e, irv, 1'($urandom_range(0, 1)), rmid);
            if (op == 5'd15 || op == 5'd16) begin
                e = base(1); e.zlow = 1; e.loin = 1;
                push_cyc(e, irv, 1'($urandom_range(0, 1)), rmid);
                e = base(1); e.zhigh = 1; e.hiin = 1; e.done = 1;
                push_cyc(e, irv, 1'($urandom_range(0, 1)), run_end);
            end else begin
                e = base(1); e.zlow = 1; e.rin = ra; e.done = 1;
                push_cyc(e, irv, 1'($urandom_range(0, 1)), run_end);
            end
        end else begin
            e = base(1); e.done = 1;
            e.ill = !(op == 5'b11010 || op == 5'b11011);
            push_cyc(e, irv, 1'($urandom_range(0, 1)), run_end);
        end
    endtask

    task automatic drain(input string name);
        stim_t s;
        outv_t e;
        int    cyc = 0;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            ir        = s.ir;
            mem_ready = s.mr;
            run       = s.rn;
            @(negedge clock);
            n_total++;
            if (act !== e)
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, e);
            else
                n_pass++;
            cyc++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b0;
        #1;
        n_total++;
        if (act !== base(1'b0))
            $display("FAIL clear_async: got %h expected %h", act, base(1'b0));
        else
            n_pass++;
        @(posedge clock);
        #1;
        clear = 1'b1;
    endtask

    task automatic test_reset();
        clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 32'h3A1B8000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_total++;
            if (act !== base(1'b0))
                $display("FAIL reset cycle %0d: got %h expected %h", i, act, base(1'b0));
            else
                n_pass++;
        end
        @(posedge clock);
        #1;
        clear = 1'b1;
    endtask

    task automatic test_ror();
        push_idle(1, 32'h3A1B8000);
        push_instr(32'h3A1B8000, 0, 0);
        push_idle(0, 32'h3A1B8000);
        drain("ror");
    endtask

    task automatic test_fetch_stall();
        push_idle(1, 32'h3A1B8000);
        push_instr(32'h3A1B8000, 3, 0);
        push_idle(0, 32'h3A1B8000);
        drain("fetch_stall");
    endtask

    task automatic test_mul();
        push_idle(1, mk_ir(5'b01111, 2, 5, 0));
        push_instr(mk_ir(5'b01111, 2, 5, 0), 0, 0);
        push_idle(0, 0);
        drain("mul");
    endtask

    task automatic test_halt_illegal();
        logic [31:0] h;
        h = mk_ir(5'b11011, 0, 0, 0);
        push_idle(1, h);
        push_instr(h, 0, 1);
        for (int i = 0; i < 3; i++) push_idle(1, h);
        drain("halt");
        pulse_clear();
        push_idle(1, mk_ir(5'b11111, 3, 4, 5));
        push_instr(mk_ir(5'b11111, 3, 4, 5), 0, 1);
        push_instr(mk_ir(5'b11010, 0, 0, 0), 1, 0);
        push_idle(0, 0);
        drain("illegal");
    endtask

    task automatic test_back_to_back();
        push_idle(1, 0);
        push_instr(mk_ir(5'b00011, 1, 2, 3), 0, 1);
        push_instr(mk_ir(5'b00100, 15, 0, 14), 1, 1);
        push_instr(mk_ir(5'b10010, 6, 9, 0), 0, 1);
        push_instr(mk_ir(5'b10000, 7, 8, 0), 2, 1);
        push_instr(mk_ir(5'b10011, 0, 11, 0), 0, 0);
        push_idle(0, 0);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        a = mk_ir(5'b00011, 9, 1, 2);
        push_idle(1, a);
        push_instr(a, 0, 1);
        void'(exp_q.pop_back()); void'(stim_q.pop_back());
        void'(exp_q.pop_back()); void'(stim_q.pop_back());
        drain("mid_pre");
        n_total++;
        if (Zin !== 1'b1 || opcode !== 5'b00011)
            $display("FAIL mid_t4: got Zin=%b opcode=%b expected Zin=1 opcode=00011", Zin, opcode);
        else
            n_pass++;
        pulse_clear();
        run = 1'b1;
        push_idle(1, a);
        push_instr(a, 0, 0);
        push_idle(0, a);
        drain("mid_post");
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        test_reset();
        test_ror();
        test_fetch_stall();
        test_mul();
        test_halt_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
